// File: rtl/htif_pkg.sv
// Shared types and tohost field helpers for the HTIF controller.
package htif_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_PUSH, ST_ACK, ST_HALT} state_t;

   localparam logic [7:0]  DEV_SYS       = 8'd0;
   localparam logic [7:0]  DEV_CON       = 8'd1;
   localparam logic [7:0]  CMD_PUTC      = 8'd1;
   localparam logic [31:0] WDT_EXIT_CODE = 32'hFFFF_FFFF;

   function automatic logic [7:0] th_dev(input logic [63:0] t);
      return t[63:56];
   endfunction

   function automatic logic [7:0] th_cmd(input logic [63:0] t);
      return t[55:48];
   endfunction

   function automatic logic [7:0] th_byte(input logic [63:0] t);
      return t[7:0];
   endfunction

   function automatic logic [31:0] th_exit_code(input logic [63:0] t);
      return t[32:1];
   endfunction

   // Acknowledge word echoes dev/cmd with a payload of 1.
   function automatic logic [63:0] th_ack(input logic [63:0] t);
      return {t[63:48], 48'd1};
   endfunction
endpackage

// File: rtl/htif_fifo.sv
// Synchronous console FIFO; extra pointer bit separates full from empty.
module htif_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head reads as zero when empty so the output is clean straight out of reset.
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/htif_ctrl.sv
// HTIF controller: decodes tohost writes into exit / putchar / ack and sequences the reply.
// Optional watchdog enabled by defining HTIF_WATCHDOG_EN.
module htif_ctrl
   import htif_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int CON_DEPTH  = 16,
   parameter int WDT_CYCLES = 1000000
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            tohost_we,
   input  logic [XLEN-1:0] tohost,
   output logic            tohost_busy,
   output logic            fromhost_we,
   output logic [XLEN-1:0] fromhost,
   output logic            con_valid,
   input  logic            con_ready,
   output logic [7:0]      con_data,
   output logic            exit_valid,
   output logic [31:0]     exit_code,
   output logic            overrun,
   output logic            wdt_expired
);
   state_t          state, state_nx;
   logic [XLEN-1:0] req;
   logic            wdt_hit;
   logic            fifo_push, fifo_full, fifo_empty;
   logic            is_exit, is_putc;

   assign is_exit = (th_dev(req) == DEV_SYS) && req[0];
   assign is_putc = (th_dev(req) == DEV_CON) && (th_cmd(req) == CMD_PUTC);

`ifdef HTIF_WATCHDOG_EN
   logic [31:0] wdt_cnt;

   assign wdt_hit = (state != ST_HALT) && (wdt_cnt == 32'(WDT_CYCLES - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wdt_cnt     <= '0;
         wdt_expired <= 1'b0;
      end else begin
         if (state != ST_HALT) wdt_cnt <= wdt_cnt + 32'd1;
         if (wdt_hit)          wdt_expired <= 1'b1;
      end
   end
`else
   assign wdt_hit     = 1'b0;
   assign wdt_expired = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Watchdog expiry preempts everything, including a same-cycle DECODE exit.
   always_comb begin
      state_nx = state;
      if (wdt_hit) begin
         state_nx = ST_HALT;
      end else begin
         case (state)
            ST_IDLE:   if (tohost_we) state_nx = ST_DECODE;
            ST_DECODE: state_nx = is_exit ? ST_HALT : (is_putc ? ST_PUSH : ST_ACK);
            ST_PUSH:   if (!fifo_full) state_nx = ST_ACK;
            ST_ACK:    state_nx = ST_IDLE;
            ST_HALT:   state_nx = ST_HALT;
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tohost_busy = (state != ST_IDLE);
      fifo_push   = (state == ST_PUSH) && !fifo_full && !wdt_hit;
      fromhost_we = (state == ST_ACK) && !wdt_hit;
      fromhost    = fromhost_we ? th_ack(req) : '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req        <= '0;
         exit_valid <= 1'b0;
         exit_code  <= '0;
         overrun    <= 1'b0;
      end else if (wdt_hit) begin
         exit_valid <= 1'b1;
         exit_code  <= WDT_EXIT_CODE;
      end else begin
         if (state == ST_IDLE && tohost_we) req <= tohost;
         if (state == ST_DECODE && is_exit) begin
            exit_valid <= 1'b1;
            exit_code  <= th_exit_code(req);
         end
         if (tohost_we && (state inside {ST_DECODE, ST_PUSH, ST_ACK})) overrun <= 1'b1;
      end
   end

   htif_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fifo_push),
      .wdata (th_byte(req)),
      .pop   (con_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .rdata (con_data)
   );

   assign con_valid = !fifo_empty;
endmodule
